// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the timer controller slice.
package timer_pkg;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned EVENTS_MAX = 15;
    localparam int unsigned ST_W       = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-PRESC_DIV tick generator with synchronous clear.
// Emits a registered one-cycle o_tick every PRESC_DIV clocks after a clear.
module tick_prescaler #(
    parameter int unsigned PRESC_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    // wide enough for divide ratios up to 16
    localparam int unsigned DIV_W = 5;

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == DIV_W'(PRESC_DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/timer_ctrl_4.sv
// Timer controller closing the count/compare loop around an external comparator.
// Optional tick prescaler enabled by defining TIMER_CTRL_4_PRESCALE_EN.
module timer_ctrl_4
    import timer_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reload,
    input  logic [CNT_W-1:0] target,
    input  logic             match,
    output logic [CNT_W-1:0] data_q,
    output logic [CNT_W-1:0] count_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] events
);

    if (PRESC_DIV < 2 || PRESC_DIV > 16) begin : g_div_chk
        $error("PRESC_DIV must be within 2..16");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_events;
    logic             r_busy;
    logic             r_done;
    logic             r_reload;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_data_nx;
    logic [CNT_W-1:0] w_count_nx;
    logic [CNT_W-1:0] w_events_nx;
    logic             w_done_nx;
    logic             w_reload_nx;
    logic             w_tick;

`ifdef TIMER_CTRL_4_PRESCALE_EN
    // prescaler restarts on every start request and every stop
    logic w_presc_clr;
    assign w_presc_clr = start | stop;

    tick_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    // Next-state and next-output logic; stop always beats start.
    always_comb begin
        w_state_nx  = r_state;
        w_data_nx   = r_data;
        w_count_nx  = r_count;
        w_events_nx = r_events;
        w_done_nx   = 1'b0;
        w_reload_nx = r_reload;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nx  = ST_RUN;
                    w_data_nx   = target;
                    w_count_nx  = '0;
                    w_events_nx = '0;
                    w_reload_nx = reload;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nx = ST_IDLE;
                    w_count_nx = '0;
                end else if (start) begin
                    w_data_nx   = target;
                    w_count_nx  = '0;
                    w_events_nx = '0;
                    w_reload_nx = reload;
                end else if (w_tick) begin
                    if (match) begin
                        w_done_nx = 1'b1;
                        if (r_events != CNT_W'(EVENTS_MAX)) begin
                            w_events_nx = r_events + CNT_W'(1);
                        end
                        if (r_reload) begin
                            w_count_nx = '0;
                        end else begin
                            w_state_nx = ST_HOLD;
                        end
                    end else begin
                        w_count_nx = r_count + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_state_nx = ST_IDLE;
                    w_count_nx = '0;
                    w_data_nx  = '0;
                end else if (start) begin
                    w_state_nx  = ST_RUN;
                    w_data_nx   = target;
                    w_count_nx  = '0;
                    w_events_nx = '0;
                    w_reload_nx = reload;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_count_nx = '0;
                w_data_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_count  <= '0;
            r_events <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_reload <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_data   <= w_data_nx;
            r_count  <= w_count_nx;
            r_events <= w_events_nx;
            r_busy   <= (w_state_nx == ST_RUN);
            r_done   <= w_done_nx;
            r_reload <= w_reload_nx;
        end
    end

    assign data_q  = r_data;
    assign count_q = r_count;
    assign events  = r_events;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_timer_ctrl_4.sv
// Bench for timer_ctrl_4 with the equality comparator modelled back-to-back.
module tb_timer_ctrl_4;

    localparam int unsigned PRESC_DIV = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       reload  = 1'b0;
    logic       nomatch = 1'b0;
    logic [3:0] target  = 4'd0;
    logic       match;
    logic [3:0] data_q;
    logic [3:0] count_q;
    logic [3:0] events;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // external comparator; nomatch emulates a disconnected comparator
    assign match = nomatch ? 1'b0 : (data_q == count_q);

    timer_ctrl_4 #(
        .PRESC_DIV (PRESC_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .reload  (reload),
        .target  (target),
        .match   (match),
        .data_q  (data_q),
        .count_q (count_q),
        .busy    (busy),
        .done    (done),
        .events  (events)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] cnt;
        logic [3:0] ev;
        logic [3:0] dat;
        logic       dat_chk;
    } exp_t;

    typedef struct {
        logic       st;
        logic       sp;
        logic       rl;
        logic [3:0] tg;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tv[35];

    function automatic exp_t mk(input logic b, input logic d, input logic [3:0] c,
                                input logic [3:0] e, input logic [3:0] dt, input logic dc);
        exp_t r;
        r.busy = b; r.done = d; r.cnt = c; r.ev = e; r.dat = dt; r.dat_chk = dc;
        return r;
    endfunction

    function automatic vec_t mkv(input logic st, input logic sp, input logic rl,
                                 input logic [3:0] tg, input exp_t e);
        vec_t v;
        v.st = st; v.sp = sp; v.rl = rl; v.tg = tg; v.e = e;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb_q.pop_front();
        chk1("busy", busy, e.busy);
        chk1("done", done, e.done);
        chk4("count_q", count_q, e.cnt);
        chk4("events", events, e.ev);
        if (e.dat_chk) chk4("data_q", data_q, e.dat);
    endtask

    // drive one cycle of inputs at the negedge, compare at the next negedge
    task automatic step(input logic st, input logic sp, input logic rl,
                        input logic [3:0] tg, input exp_t e);
        start = st; stop = sp; reload = rl; target = tg;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_pop();
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk4({tag, "_count"}, count_q, 4'd0);
        chk4({tag, "_events"}, events, 4'd0);
        chk4({tag, "_data"}, data_q, 4'd0);
    endtask

    initial begin
        int dn[3];
        int n;

        // idle vectors carry target 0; expected values hold after the edge
        tv[0]  = mkv(0, 0, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 1));
        tv[1]  = mkv(1, 0, 0, 4'd5, mk(1, 0, 4'd0, 4'd0, 4'd5, 1));
        tv[2]  = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd1, 4'd0, 4'd5, 1));
        tv[3]  = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd2, 4'd0, 4'd5, 1));
        tv[4]  = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd3, 4'd0, 4'd5, 1));
        tv[5]  = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd4, 4'd0, 4'd5, 1));
        tv[6]  = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd5, 4'd0, 4'd5, 1));
        tv[7]  = mkv(0, 0, 0, 4'd0, mk(0, 1, 4'd5, 4'd1, 4'd5, 1));
        tv[8]  = mkv(0, 0, 0, 4'd0, mk(0, 0, 4'd5, 4'd1, 4'd5, 1));
        tv[9]  = mkv(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd1, 4'd0, 1));
        tv[10] = mkv(1, 1, 0, 4'd7, mk(0, 0, 4'd0, 4'd1, 4'd0, 1));
        tv[11] = mkv(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd1, 4'd0, 1));
        tv[12] = mkv(1, 0, 0, 4'd9, mk(1, 0, 4'd0, 4'd0, 4'd9, 1));
        tv[13] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd1, 4'd0, 4'd9, 1));
        tv[14] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd2, 4'd0, 4'd9, 1));
        tv[15] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd3, 4'd0, 4'd9, 1));
        tv[16] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd4, 4'd0, 4'd9, 1));
        tv[17] = mkv(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 0));
        tv[18] = mkv(0, 0, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 0));
        tv[19] = mkv(1, 0, 0, 4'd2, mk(1, 0, 4'd0, 4'd0, 4'd2, 1));
        tv[20] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd1, 4'd0, 4'd2, 1));
        tv[21] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd2, 4'd0, 4'd2, 1));
        tv[22] = mkv(1, 0, 0, 4'd6, mk(1, 0, 4'd0, 4'd0, 4'd6, 1));
        tv[23] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd1, 4'd0, 4'd6, 1));
        tv[24] = mkv(1, 1, 0, 4'd3, mk(0, 0, 4'd0, 4'd0, 4'd0, 0));
        tv[25] = mkv(1, 0, 1, 4'd0, mk(1, 0, 4'd0, 4'd0, 4'd0, 1));
        tv[26] = mkv(0, 0, 0, 4'd0, mk(1, 1, 4'd0, 4'd1, 4'd0, 1));
        tv[27] = mkv(0, 0, 0, 4'd0, mk(1, 1, 4'd0, 4'd2, 4'd0, 1));
        tv[28] = mkv(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd2, 4'd0, 0));
        tv[29] = mkv(1, 0, 0, 4'd1, mk(1, 0, 4'd0, 4'd0, 4'd1, 1));
        tv[30] = mkv(0, 0, 0, 4'd0, mk(1, 0, 4'd1, 4'd0, 4'd1, 1));
        tv[31] = mkv(0, 0, 0, 4'd0, mk(0, 1, 4'd1, 4'd1, 4'd1, 1));
        tv[32] = mkv(1, 0, 0, 4'd4, mk(1, 0, 4'd0, 4'd0, 4'd4, 1));
        tv[33] = mkv(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 0));
        tv[34] = mkv(0, 0, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 0));

        #1 rst_n = 1'b0;
        #11;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef TIMER_CTRL_4_PRESCALE_EN
        for (int i = 0; i < 35; i++) begin
            step(tv[i].st, tv[i].sp, tv[i].rl, tv[i].tg, tv[i].e);
        end

        // periodic target 3: done every 4 cycles, first in cycle 5
        step(1, 0, 1, 4'd3, mk(1, 0, 4'd0, 4'd0, 4'd3, 1));
        for (int k = 2; k <= 21; k++) begin
            step(0, 0, 0, 4'd0,
                 mk(1, (k >= 5 && (k - 5) % 4 == 0) ? 1'b1 : 1'b0,
                    4'((k - 1) % 4), (k >= 5) ? 4'((k - 5) / 4 + 1) : 4'd0, 4'd3, 1));
        end
        chk4("reload_events", events, 4'd5);
        step(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd5, 4'd3, 0));

        // target 0 periodic: done every cycle, events saturate at 15
        step(1, 0, 1, 4'd0, mk(1, 0, 4'd0, 4'd0, 4'd0, 1));
        for (int k = 2; k <= 20; k++) begin
            step(0, 0, 0, 4'd0,
                 mk(1, 1, 4'd0, (k - 1 > 15) ? 4'd15 : 4'(k - 1), 4'd0, 1));
        end
        step(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd15, 4'd0, 0));

        // comparator silent: count wraps 15 -> 0 and never completes
        nomatch = 1'b1;
        step(1, 0, 0, 4'd3, mk(1, 0, 4'd0, 4'd0, 4'd3, 1));
        for (int k = 2; k <= 18; k++) begin
            step(0, 0, 0, 4'd0, mk(1, 0, 4'((k - 1) % 16), 4'd0, 4'd3, 1));
        end
        step(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd3, 0));
        nomatch = 1'b0;

        // asynchronous reset while counting at count_q = 7
        step(1, 0, 0, 4'd9, mk(1, 0, 4'd0, 4'd0, 4'd9, 1));
        for (int k = 2; k <= 8; k++) begin
            step(0, 0, 0, 4'd0, mk(1, 0, 4'(k - 1), 4'd0, 4'd9, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 4'd0, mk(0, 0, 4'd0, 4'd0, 4'd0, 1));
        end
`else
        // prescaled periodic target 2: done period (2+1)*PRESC_DIV
        step(1, 0, 1, 4'd2, mk(1, 0, 4'd0, 4'd0, 4'd2, 1));
        n = 0;
        for (int k = 2; k <= 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && n < 3) begin
                dn[n] = k;
                n++;
            end
        end
        if (n < 3) begin
            total++;
            bad++;
            $display("FAIL presc_done_count: got %0d pulses, expected at least 3", n);
        end else begin
            chk_int("presc_period_1", dn[1] - dn[0], 3 * PRESC_DIV);
            chk_int("presc_period_2", dn[2] - dn[1], 3 * PRESC_DIV);
        end
        step(0, 1, 0, 4'd0, mk(0, 0, 4'd0, 4'd3, 4'd2, 0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_4.md
# timer_ctrl_4

4-bit timer controller that drives the `count` operand of the 4-bit equality comparator and consumes its `out` match flag. On `start` it latches a target value, presents it on `data_q`, and advances `count_q` each tick until the comparator reports equality. It then either stops or reloads, depending on `reload`. It sits directly upstream and downstream of the comparator, closing the count/compare loop of the timer datapath.

## Interface
- `PRESC_DIV`, default 4: tick divider ratio, 2..16. Used only when `TIMER_CTRL_4_PRESCALE_EN` is defined.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request: latch `target` and begin counting.
- `stop`  in  1  one-cycle request: abort and return to IDLE.
- `reload`  in  1  sampled with `start`; 1 = periodic mode, 0 = one-shot.
- `target`  in  4  compare value, latched on accepted `start`.
- `match`  in  1  comparator `out`; high when `data_q == count_q`.
- `data_q`  out  4  latched target, wired to comparator `data`.
- `count_q`  out  4  running count, wired to comparator `count`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle registered pulse per match event.
- `events`  out  4  match events since last `start`; saturates at 15.

## Operation
- States: IDLE, RUN, HOLD. Encoding comes from the shared package.
- Reset: state IDLE; `data_q`, `count_q`, `events`, `busy`, `done` all 0.
- IDLE:
  - `start` → RUN; `data_q` ← `target`; `count_q` ← 0; `events` ← 0; reload mode latched.
  - `stop` is ignored.
- RUN, each tick:
  - `match` = 0: `count_q` ← `count_q` + 1, modulo 16. A disconnected comparator wraps 15→0; this is not an error.
  - `match` = 1: `done` pulses next cycle and `events` ← `events` + 1, saturating at 15.
    - Reload mode: `count_q` ← 0, stay in RUN.
    - One-shot mode: `count_q` holds, go to HOLD.
- HOLD:
  - `count_q` and `data_q` hold; `busy` = 0.
  - `start` → RUN as from IDLE.
  - `stop` → IDLE, clearing `count_q` and `data_q`.
- `start` in RUN: restart. Re-latch `target`, `count_q` ← 0, `events` ← 0, and suppress any `done` from a `match` in the same cycle.
- `stop` in RUN → IDLE; `count_q` ← 0, no `done`.
- `start` and `stop` in the same cycle: `stop` wins in every state.
- `target` = 0: match on the first RUN cycle. In reload mode `done` is then high every cycle.
- `match` is ignored outside RUN.

## Timing
- Accepted `start` at edge 0: `busy` high from cycle 1, `count_q` = 0 in cycle 1.
- Without prescaler: match seen in cycle N+1 for `target` = N; `done` high in cycle N+2.
- Reload period is N+1 cycles.
- `done` is exactly one cycle wide and never asserted in IDLE or on the reset-release cycle.
- `rst_n` low mid-RUN clears all outputs asynchronously. Operation resumes only after a new `start`.

## Configuration
- `TIMER_CTRL_4_PRESCALE_EN` defined:
  - A divide-by-`PRESC_DIV` tick enable gates all RUN count and match evaluation.
  - The prescaler clears on every accepted `start` and on `stop`.
  - Reload period becomes (N+1)×`PRESC_DIV` cycles.
- Undefined: tick is constant 1 and the prescaler logic is absent.

## Structure
- Shared package `timer_pkg`: state enum (IDLE/RUN/HOLD), `CNT_W` = 4, `EVENTS_MAX` = 15.
- One sub-module, `tick_prescaler`: counter with clear input, producing a one-cycle tick every `PRESC_DIV` clocks. Instantiated only under the macro.
- The comparator stays external. The top-level bench instantiates `timer_ctrl_4` plus the comparator wired back-to-back.

## Test plan
- Reset, then `start` with `target` = 5, `reload` = 0 → `count_q` 0..5, `done` in cycle 7, HOLD with `count_q` = 5, `events` = 1.
- `target` = 3, `reload` = 1 for 20 cycles → `done` every 4 cycles, `events` = 5.
- `target` = 9 RUN, `stop` at `count_q` = 4 → IDLE next cycle, `count_q` = 0, no `done`.
- `start` and `stop` together in IDLE → stays IDLE, `busy` = 0.
- `rst_n` low at `count_q` = 7 → all outputs 0 immediately; `done` never pulses after release.
- With macro and `PRESC_DIV` = 4, `target` = 2, `reload` = 1 → `done` every 12 cycles; `match` tied 0 → `count_q` wraps 15→0.
